// File: rtl/string_hw_ctrl_if.sv
// Avalon-MM slave bus between the host and the string accelerator controller.
// The host side drives the strobes and data; the controller returns read data and the interrupt.
interface string_hw_ctrl_if;
  logic        chipselect;
  logic [3:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output chipselect, address, write, writedata, read,
    input  readdata, irq
  );

  modport slave (
    input  chipselect, address, write, writedata, read,
    output readdata, irq
  );
endinterface

// File: rtl/string_hw_ctrl.sv
// Host-facing controller for a string accelerator.
// Holds the A/B operands and the RESULT words, and hands one operation at a time to the accelerator.
// Each operation is a go/done four-phase handshake. A cycle budget guards both done edges;
// when it runs out the accelerator gets a one-cycle reset and the error flag is set.
module string_hw_ctrl #(
  parameter int MAX_BLOCKS = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  string_hw_ctrl_if.slave           bus,
  output logic                      acc_go,
  output logic [3:0]                acc_index,
  output logic [7:0]                acc_length,
  output logic [MAX_BLOCKS*32-1:0]  acc_A,
  output logic [MAX_BLOCKS*32-1:0]  acc_B,
  input  logic                      acc_done,
  input  logic [MAX_BLOCKS*32-1:0]  acc_result,
  output logic                      acc_reset
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, RELEASE, ABORT} state_t;

  state_t                   state;
  logic [CW-1:0]            counter;
  logic                     done_flag;
  logic                     err;
  logic                     irq_en;
  logic [3:0]               index_reg;
  logic [7:0]               length_reg;
  logic                     acc_reset_q;
  logic [MAX_BLOCKS*32-1:0] a_reg;
  logic [MAX_BLOCKS*32-1:0] b_reg;
  logic [MAX_BLOCKS*32-1:0] result_reg;
  logic [31:0]              read_word;

  logic wr_en;
  logic rd_en;
  logic ctrl_wr;
  logic busy;

  assign wr_en   = bus.chipselect & bus.write;
  assign rd_en   = bus.chipselect & bus.read;
  assign ctrl_wr = wr_en && (bus.address == 4'd0);
  assign busy    = (state != IDLE);

  assign acc_A      = a_reg;
  assign acc_B      = b_reg;
  assign acc_index  = index_reg;
  assign acc_length = length_reg;
  assign acc_reset  = acc_reset_q | ~reset_n;
  assign bus.irq    = done_flag & irq_en;

  // Operand words are writable only while idle so they stay stable for the accelerator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (wr_en && !busy) begin
      for (int k = 0; k < MAX_BLOCKS; k++) begin
        if (int'(bus.address) == k + 1)
          a_reg[k*32 +: 32] <= bus.writedata;
        if (int'(bus.address) == MAX_BLOCKS + 1 + k)
          b_reg[k*32 +: 32] <= bus.writedata;
      end
    end
  end

  // Handshake FSM together with the control fields, flags, timeout counter and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      counter     <= '0;
      acc_go      <= 1'b0;
      acc_reset_q <= 1'b0;
      done_flag   <= 1'b0;
      err         <= 1'b0;
      irq_en      <= 1'b0;
      index_reg   <= '0;
      length_reg  <= '0;
      result_reg  <= '0;
    end else begin
      acc_reset_q <= 1'b0;
      if (ctrl_wr) begin
        irq_en <= bus.writedata[3];
        if (bus.writedata[1]) begin
          done_flag <= 1'b0;
          err       <= 1'b0;
        end
        if (state == IDLE) begin
          index_reg  <= bus.writedata[7:4];
          length_reg <= bus.writedata[15:8];
        end
      end
      case (state)
        IDLE: begin
          acc_go <= 1'b0;
          if (ctrl_wr && bus.writedata[0]) begin
            if (bus.writedata[7:4] <= 4'd4) begin
              done_flag <= 1'b0;
              err       <= 1'b0;
              counter   <= '0;
              acc_go    <= 1'b1;
              state     <= WAIT_DONE;
            end else begin
              err       <= 1'b1;
              done_flag <= 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (acc_done) begin
            result_reg <= acc_result;
            counter    <= '0;
            acc_go     <= 1'b0;
            state      <= RELEASE;
          end else if (counter == LAST_COUNT) begin
            acc_go      <= 1'b0;
            acc_reset_q <= 1'b1;
            state       <= ABORT;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RELEASE: begin
          acc_go <= 1'b0;
          if (!acc_done) begin
            done_flag <= 1'b1;
            state     <= IDLE;
          end else if (counter == LAST_COUNT) begin
            acc_reset_q <= 1'b1;
            state       <= ABORT;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ABORT: begin
          acc_go    <= 1'b0;
          err       <= 1'b1;
          done_flag <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          acc_go <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Read mux over STATUS, A, B and RESULT; unmapped addresses return zero.
  always_comb begin
    read_word = '0;
    if (bus.address == 4'd0)
      read_word = {16'h0000, length_reg, index_reg, irq_en, err, done_flag, busy};
    for (int k = 0; k < MAX_BLOCKS; k++) begin
      if (int'(bus.address) == k + 1)
        read_word = a_reg[k*32 +: 32];
      if (int'(bus.address) == MAX_BLOCKS + 1 + k)
        read_word = b_reg[k*32 +: 32];
      if (int'(bus.address) == 2*MAX_BLOCKS + 1 + k)
        read_word = result_reg[k*32 +: 32];
    end
  end

  // Registered read data, valid the cycle after the read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bus.readdata <= '0;
    else if (rd_en)
      bus.readdata <= read_word;
  end

endmodule

// File: tb/tb_string_hw_ctrl.sv
// Directed testbench for string_hw_ctrl with a small behavioural accelerator.
// The accelerator supports index 0 (equality) and index 1 (uppercase).
module tb_string_hw_ctrl;
  localparam int MB = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          acc_go;
  logic [3:0]    acc_index;
  logic [7:0]    acc_length;
  logic [MB*32-1:0] acc_A;
  logic [MB*32-1:0] acc_B;
  logic          acc_done = 1'b0;
  logic [MB*32-1:0] acc_result = '0;
  logic          acc_reset;

  logic          model_en = 1'b1;
  int            model_cnt = 0;
  int            go_rises = 0;
  int            go_cycles = 0;
  int            rst_cycles = 0;
  logic          go_prev = 1'b0;

  int            total = 0;
  int            bad = 0;

  string_hw_ctrl_if bus();

  string_hw_ctrl #(.MAX_BLOCKS(MB), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .acc_go     (acc_go),
    .acc_index  (acc_index),
    .acc_length (acc_length),
    .acc_A      (acc_A),
    .acc_B      (acc_B),
    .acc_done   (acc_done),
    .acc_result (acc_result),
    .acc_reset  (acc_reset)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [MB*32-1:0] modelCompute(input logic [3:0] idx,
                                                     input logic [MB*32-1:0] a,
                                                     input logic [MB*32-1:0] b);
    logic [MB*32-1:0] r;
    logic [7:0] ch;
    r = '0;
    if (idx == 4'd0) begin
      r[0] = (a == b);
    end else if (idx == 4'd1) begin
      for (int i = 0; i < MB*4; i++) begin
        ch = a[i*8 +: 8];
        if (ch >= 8'h61 && ch <= 8'h7a) ch = ch - 8'h20;
        r[i*8 +: 8] = ch;
      end
    end
    return r;
  endfunction

  // Accelerator model answers three cycles after go and holds done until go drops
  always @(posedge clk) begin
    if (!model_en || acc_reset) begin
      acc_done  <= 1'b0;
      model_cnt <= 0;
    end else if (acc_go && !acc_done) begin
      if (model_cnt == 2) begin
        acc_done   <= 1'b1;
        acc_result <= modelCompute(acc_index, acc_A, acc_B);
      end
      model_cnt <= model_cnt + 1;
    end else if (!acc_go) begin
      acc_done  <= 1'b0;
      model_cnt <= 0;
    end
  end

  // Handshake monitor sampled on the falling edge
  always @(negedge clk) begin
    go_prev <= acc_go;
    if (acc_go && !go_prev) go_rises <= go_rises + 1;
    if (acc_go) go_cycles <= go_cycles + 1;
    if (acc_reset && reset_n) rst_cycles <= rst_cycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single-cycle bus write, called on a falling edge and returning on the next one
  task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < 60; i++) begin
      readReg(4'd0, s);
      if (!s[0]) break;
    end
    checkOutput(tag, {63'b0, s[0]}, 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    int g0, r0, n0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst acc_reset", {63'b0, acc_reset}, 64'd1);
    checkOutput("rst acc_go", {63'b0, acc_go}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst acc_reset released", {63'b0, acc_reset}, 64'd0);
    readReg(4'd0, d); checkOutput("rst status", {32'b0, d}, 64'd0);
    readReg(4'd5, d); checkOutput("rst result0", {32'b0, d}, 64'd0);
    readReg(4'd1, d); checkOutput("rst A0", {32'b0, d}, 64'd0);
    checkOutput("rst irq", {63'b0, bus.irq}, 64'd0);

    // Uppercase "abcdEFgh"
    n0 = go_rises;
    applyStimulus(4'd1, 32'h64636261);
    applyStimulus(4'd2, 32'h68674645);
    applyStimulus(4'd0, 32'h0000_0811);
    checkOutput("upper acc_length", {56'b0, acc_length}, 64'd8);
    waitIdle("upper idle");
    readReg(4'd5, d); checkOutput("upper result0", {32'b0, d}, 64'h44434241);
    readReg(4'd6, d); checkOutput("upper result1", {32'b0, d}, 64'h48474645);
    readReg(4'd0, d); checkOutput("upper status", {32'b0, d}, 64'h0812);
    checkOutput("upper go rises", 64'(go_rises - n0), 64'd1);
    checkOutput("upper go low", {63'b0, acc_go}, 64'd0);

    // RESULT is read-only; unmapped addresses read zero
    applyStimulus(4'd5, 32'hFFFF_FFFF);
    readReg(4'd5, d); checkOutput("result readonly", {32'b0, d}, 64'h44434241);
    applyStimulus(4'd7, 32'h1234_5678);
    readReg(4'd7, d); checkOutput("addr7 zero", {32'b0, d}, 64'd0);
    readReg(4'd15, d); checkOutput("addr15 zero", {32'b0, d}, 64'd0);

    // Timeout: accelerator never answers
    model_en = 1'b0;
    g0 = go_cycles;
    r0 = rst_cycles;
    applyStimulus(4'd0, 32'h0000_0011);
    waitIdle("timeout idle");
    checkOutput("timeout go cycles", 64'(go_cycles - g0), 64'd16);
    checkOutput("timeout reset pulse", 64'(rst_cycles - r0), 64'd1);
    readReg(4'd0, d); checkOutput("timeout status", {32'b0, d}, 64'h16);
    readReg(4'd5, d); checkOutput("timeout result0 kept", {32'b0, d}, 64'h44434241);
    readReg(4'd6, d); checkOutput("timeout result1 kept", {32'b0, d}, 64'h48474645);
    model_en = 1'b1;

    // Equality compare "hello!!!" vs "hello!!!" then vs "hellO!!!"
    applyStimulus(4'd1, 32'h6c6c6568);
    applyStimulus(4'd2, 32'h2121216f);
    applyStimulus(4'd3, 32'h6c6c6568);
    applyStimulus(4'd4, 32'h2121216f);
    applyStimulus(4'd0, 32'h0000_0001);
    waitIdle("cmp eq idle");
    checkOutput("cmp acc_A", acc_A, 64'h2121216f_6c6c6568);
    readReg(4'd5, d); checkOutput("cmp eq result0", {32'b0, d}, 64'd1);
    readReg(4'd0, d); checkOutput("cmp eq status", {32'b0, d}, 64'h02);
    applyStimulus(4'd4, 32'h2121214f);
    applyStimulus(4'd0, 32'h0000_0001);
    waitIdle("cmp ne idle");
    readReg(4'd5, d); checkOutput("cmp ne result0", {32'b0, d}, 64'd0);
    readReg(4'd6, d); checkOutput("cmp ne result1", {32'b0, d}, 64'd0);

    // Illegal index never starts the accelerator
    n0 = go_rises;
    applyStimulus(4'd0, 32'h0000_0071);
    readReg(4'd0, d); checkOutput("bad index status", {32'b0, d}, 64'h76);
    @(negedge clk);
    checkOutput("bad index go", {63'b0, acc_go}, 64'd0);
    checkOutput("bad index go rises", 64'(go_rises - n0), 64'd0);
    applyStimulus(4'd0, 32'h0000_0002);
    readReg(4'd0, d); checkOutput("clear status", {32'b0, d}, 64'd0);

    // Writes while busy are ignored except irq_en; interrupt follows done_flag
    applyStimulus(4'd0, 32'h0000_0009);
    applyStimulus(4'd2, 32'hdeadbeef);
    applyStimulus(4'd0, 32'h0000_0539);
    waitIdle("busy idle");
    readReg(4'd2, d); checkOutput("busy A1 kept", {32'b0, d}, 64'h2121216f);
    checkOutput("irq set", {63'b0, bus.irq}, 64'd1);
    readReg(4'd0, d); checkOutput("busy status", {32'b0, d}, 64'h0A);
    applyStimulus(4'd0, 32'h0000_000A);
    checkOutput("irq cleared", {63'b0, bus.irq}, 64'd0);
    readReg(4'd0, d); checkOutput("after clear status", {32'b0, d}, 64'h08);

    // Reset in the middle of an operation
    applyStimulus(4'd0, 32'h0000_0011);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst acc_go", {63'b0, acc_go}, 64'd0);
    checkOutput("midrst acc_reset", {63'b0, acc_reset}, 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst acc_reset released", {63'b0, acc_reset}, 64'd0);
    readReg(4'd0, d); checkOutput("midrst status", {32'b0, d}, 64'd0);
    readReg(4'd5, d); checkOutput("midrst result0", {32'b0, d}, 64'd0);
    readReg(4'd1, d); checkOutput("midrst A0", {32'b0, d}, 64'd0);
    checkOutput("midrst irq", {63'b0, bus.irq}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/string_hw_ctrl.md
STRING_HW_CTRL -- requirements
Module: string_hw_ctrl

Interface
REQ-001 Parameter MAX_BLOCKS, default 2: number of 32-bit words per string operand; accelerator operands are MAX_BLOCKS*4 bytes.
REQ-002 Parameter TIMEOUT, default 1000: maximum cycles spent waiting on either done edge before an abort.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 chipselect  in  1  Avalon-MM slave select.
REQ-006 address  in  4  word address; supports MAX_BLOCKS 1..5.
REQ-007 write  in  1  write strobe, qualified by chipselect.
REQ-008 writedata  in  32  write data.
REQ-009 read  in  1  read strobe, qualified by chipselect.
REQ-010 readdata  out  32  read data, fixed read latency 1.
REQ-011 irq  out  1  level interrupt = done_flag AND irq_en.
REQ-012 acc_go  out  1  go to accelerator.
REQ-013 acc_index  out  4  function select to accelerator.
REQ-014 acc_length  out  8  search length to accelerator.
REQ-015 acc_A, acc_B  out  MAX_BLOCKS*4 bytes each  operands; byte 0 = first character.
REQ-016 acc_done  in  1  done from accelerator.
REQ-017 acc_result  in  MAX_BLOCKS*4 bytes  result from accelerator.
REQ-018 acc_reset  out  1  active-high synchronous reset to accelerator.

Function
REQ-019 Register map (word address): 0 CTRL/STATUS; 1..MAX_BLOCKS A words; MAX_BLOCKS+1..2*MAX_BLOCKS B words; 2*MAX_BLOCKS+1..3*MAX_BLOCKS RESULT words (read-only); other addresses read 0, writes ignored.
REQ-020 Word k of A/B/RESULT holds bytes 4k..4k+3, byte 4k in bits [7:0] (little-endian, C string order).
REQ-021 CTRL write: bit0 start, bit1 clear (done_flag and err to 0), bit3 irq_en, [7:4] index, [15:8] length.
REQ-022 STATUS read: bit0 busy, bit1 done_flag, bit2 err, bit3 irq_en, [7:4] index, [15:8] length, others 0.
REQ-023 FSM states IDLE, WAIT_DONE, RELEASE, ABORT; busy = state != IDLE.
REQ-024 IDLE: acc_go=0; start with index<=4 -> clear done_flag and err, load timeout counter 0, go WAIT_DONE.
REQ-025 IDLE: start with index>4 -> err=1, done_flag=1, acc_go never asserted, stay IDLE.
REQ-026 WAIT_DONE: acc_go=1; acc_done=1 -> capture acc_result into RESULT, counter 0, go RELEASE.
REQ-027 RELEASE: acc_go=0; acc_done=0 -> done_flag=1, go IDLE.
REQ-028 WAIT_DONE/RELEASE: counter increments each cycle; counter reaching TIMEOUT-1 without exit condition -> ABORT.
REQ-029 ABORT: one cycle, acc_go=0, acc_reset=1, err=1, done_flag=1, RESULT unchanged, then IDLE.
REQ-030 While busy, writes to A, B, and CTRL fields/start are ignored; clear bit and irq_en still honoured.
REQ-031 Same-cycle start and clear in IDLE: start wins (flags cleared, operation begins).
REQ-032 acc_index/acc_length/acc_A/acc_B driven directly from registers, stable throughout an operation.
REQ-033 Reads never have side effects; readdata registered, valid cycle after read.

Reset
REQ-034 reset_n low: state IDLE, acc_go=0, all registers, RESULT, flags, irq_en, counter, readdata = 0.
REQ-035 acc_reset=1 while reset_n low; reset mid-operation aborts immediately with no done_flag or err set.

Verification
REQ-036 Write A="abcdEFgh", index=1, start; model returns after 3 cycles -> RESULT="ABCDEFGH", done_flag=1, busy=0, go rose once and fell before done_flag.
REQ-037 A="hello!!!", B="hello!!!", index=0 -> RESULT word 0 = 1; B="hellO!!!" -> RESULT word 0 = 0.
REQ-038 index=7, start -> err=1, done_flag=1, acc_go stays 0, STATUS reads 0x0000_0076 (index 7, done, err, length 0).
REQ-039 acc_done tied 0, TIMEOUT=16, start -> ABORT after 16 cycles: acc_reset pulse 1 cycle, err=1, RESULT unchanged.
REQ-040 Write A word 1 while busy -> A unchanged; irq_en=1 then completion -> irq=1; clear -> irq=0.
REQ-041 reset_n low in WAIT_DONE -> acc_go=0 and acc_reset=1 same cycle, all STATUS bits 0 after release.
